ahb_block_ram_bridge: RTL and testbench

AHB-Lite slave that initiates all accesses on the single-port block RAM interface (`addra`/`dina`/`wea`/`douta`) holding the Cortex-M0 code and data image. It converts AHB address and data phases into RAM reads and byte-lane writes. It delivers zero-wait-state reads and writes. It inserts exactly one wait state when a read follows a write, because the RAM port is busy with the write in that cycle.

---
 rtl/ahb_ram_pkg.sv | 33 +++
 rtl/ahb_ram_strb_gen.sv | 29 ++
 rtl/ahb_block_ram_bridge.sv | 113 +++++++++++
 tb/tb_ahb_block_ram_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_ram_pkg.sv
// Shared types and constants for the AHB-Lite to block RAM bridge.
package ahb_ram_pkg;

  // Bridge data-phase states; the error states are only reachable with AHB_RAM_ERR_EN.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRd     = 3'd1,
    StWr     = 3'd2,
    StRdWait = 3'd3,
    StErr1   = 3'd4,
    StErr2   = 3'd5
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // NONSEQ and SEQ both carry HTRANS[1]; IDLE and BUSY do not.
  function automatic logic trans_active(logic [1:0] htrans);
    return (htrans & HTRANS_NONSEQ) != HTRANS_IDLE;
  endfunction

  function automatic logic resp_of(logic err);
    return err ? RESP_ERROR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/ahb_ram_strb_gen.sv
// Byte-lane strobe decode from HSIZE and the low address bits, plus alignment flags.
module ahb_ram_strb_gen
  import ahb_ram_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] strb_o,
  output logic       misalign_o,
  output logic       oversize_o
);

  // Lane decode; oversize transfers fall through to a full-word strobe.
  always_comb begin
    strb_o     = 4'b1111;
    misalign_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        strb_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
        misalign_o = addr_lo_i[0];
      end
      HSIZE_WORD: misalign_o = (addr_lo_i != 2'b00);
      default: ;
    endcase
  end

  assign oversize_o = (size_i > HSIZE_WORD);

endmodule

// File: rtl/ahb_block_ram_bridge.sv
// AHB-Lite slave driving a single-port block RAM. Reads are zero-wait except a read
// directly after a write, which stalls one cycle while the RAM port finishes the write.
// Optional feature: define AHB_RAM_ERR_EN for a two-cycle ERROR on misaligned/oversize transfers.
module ahb_block_ram_bridge
  import ahb_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  input  logic [31:0]           douta
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            strb_q, strb_d;

  logic       accept;
  logic [3:0] strb;
  logic       misalign;
  logic       oversize;
  logic       xfer_err;

  ahb_ram_strb_gen u_strb_gen (
    .size_i     (HSIZE),
    .addr_lo_i  (HADDR[1:0]),
    .strb_o     (strb),
    .misalign_o (misalign),
    .oversize_o (oversize)
  );

  assign accept = HSEL & HREADY & trans_active(HTRANS);

`ifdef AHB_RAM_ERR_EN
  assign xfer_err = misalign | oversize;
`else
  assign xfer_err = 1'b0;
  logic unused_err;
  assign unused_err = misalign ^ oversize;
`endif

  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

  // Next-state: stall/error states advance unconditionally, otherwise follow the accepted phase.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    if (state_q == StRdWait) begin
      state_d = StRd;
    end else if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (accept) begin
      addr_d = HADDR[ADDR_WIDTH+1:2];
      strb_d = strb;
      if (xfer_err) begin
        state_d = StErr1;
      end else if (HWRITE) begin
        state_d = StWr;
      end else if (state_q == StWr) begin
        // RAM port is busy writing this cycle, so the read is reissued next cycle.
        state_d = StRdWait;
      end else begin
        state_d = StRd;
      end
    end else begin
      state_d = StIdle;
    end
  end

  // State and captured address-phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
    end
  end

  // RAM port and bus outputs; the live HADDR feeds the RAM so reads return in their data phase.
  always_comb begin
    addra     = ((state_q == StWr) || (state_q == StRdWait)) ? addr_q : HADDR[ADDR_WIDTH+1:2];
    wea       = (state_q == StWr) ? strb_q : 4'b0000;
    HREADYOUT = !((state_q == StRdWait) || (state_q == StErr1));
    dina      = HWDATA;
    HRDATA    = douta;
  end

`ifdef AHB_RAM_ERR_EN
  assign HRESP = resp_of((state_q == StErr1) || (state_q == StErr2));
`else
  assign HRESP = resp_of(1'b0);
`endif

endmodule

// File: tb/tb_ahb_block_ram_bridge.sv
// Bench for ahb_block_ram_bridge: directed scenarios plus random AHB traffic checked
// against a transaction-level memory model. Honours AHB_RAM_ERR_EN if defined.
module tb_ahb_block_ram_bridge;

  localparam int AW = 14;
  localparam int NW = 64;
`ifdef AHB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic [3:0]    wea;
  logic [31:0]   douta;
  logic          preload;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_block_ram_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .addra     (addra),
    .dina      (dina),
    .wea       (wea),
    .douta     (douta)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'(32'h9E3779B9 * (i + 1)) ^ 32'h0F0F_0F0F;
  endfunction

  // Block RAM: byte-lane writes, registered read.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge HCLK) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) ram[i] <= init_word(i);
    end else begin
      for (int b = 0; b < 4; b++) if (wea[b]) ram[addra][8*b +: 8] <= dina[8*b +: 8];
    end
    douta <= ram[addra];
  end

  typedef struct {
    bit          valid;
    bit          sel;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] ref_mem [0:NW-1];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rdata;
  logic [3:0]  last_wea;
  int          stalls;
  int          resp_cycles;

  function automatic xfer_t mk(bit v, bit s, bit w, logic [31:0] a, logic [2:0] sz,
                               logic [31:0] d);
    xfer_t x;
    x.valid = v; x.sel = s; x.write = w; x.addr = a; x.size = sz; x.wdata = d;
    return x;
  endfunction

  task automatic add_wr(logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    q.push_back(mk(1'b1, 1'b1, 1'b1, a, sz, d));
  endtask
  task automatic add_rd(logic [31:0] a, logic [2:0] sz);
    q.push_back(mk(1'b1, 1'b1, 1'b0, a, sz, 32'h0));
  endtask
  task automatic add_idle();
    q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 3'd2, 32'h0));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Lanes a transfer touches, from the transfer size and byte address.
  function automatic logic [3:0] exp_strb(logic [31:0] a, logic [2:0] sz);
    if (sz == 3'd0) return 4'(1 << a[1:0]);
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit is_err(logic [31:0] a, logic [2:0] sz);
    return ERR_EN && ((sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00));
  endfunction

  // Plays the queued transfers as a pipelined AHB master and checks every data-phase cycle.
  task automatic run_queue();
    xfer_t dp;
    xfer_t ap;
    int    idx = 0;
    int    waited = 0;
    int    cyc = 0;
    int    limit;
    bit    prev_wr = 1'b0;
    bit    rdy, exp_rdy, derr;
    limit = 3 * q.size() + 10;
    dp = mk(1'b0, 1'b1, 1'b0, 32'h0, 3'd2, 32'h0);
    stalls = 0;
    resp_cycles = 0;
    while (idx < q.size() || dp.valid) begin
      ap = (idx < q.size()) ? q[idx] : mk(1'b0, 1'b1, 1'b0, 32'h0, 3'd2, 32'h0);
      HSEL   = ap.sel;
      HTRANS = ap.valid ? 2'b10 : 2'b00;
      HADDR  = ap.addr;
      HWRITE = ap.write;
      HSIZE  = ap.size;
      HWDATA = dp.wdata;
      @(negedge HCLK);
      derr = dp.valid && is_err(dp.addr, dp.size);
      if (derr) exp_rdy = (waited != 0);
      else if (dp.valid && !dp.write && prev_wr) exp_rdy = (waited != 0);
      else exp_rdy = 1'b1;
      rdy = HREADYOUT;
      check("hreadyout", HREADYOUT, exp_rdy);
      check("hresp", HRESP, derr);
      if (!rdy) stalls++;
      if (HRESP) resp_cycles++;
      if (dp.valid && dp.write && !derr) begin
        check("wea", wea, exp_strb(dp.addr, dp.size));
        check("addra", addra, (dp.addr >> 2) & ((1 << AW) - 1));
        last_wea = wea;
      end else begin
        check("wea_quiet", wea, 4'b0000);
      end
      if (dp.valid && !dp.write && !derr && rdy) begin
        check("hrdata", HRDATA, ref_mem[dp.addr[7:2]]);
        last_rdata = HRDATA;
      end
      @(posedge HCLK);
      #1;
      cyc++;
      if (rdy) begin
        if (dp.valid && dp.write && !derr) begin
          for (int b = 0; b < 4; b++)
            if (exp_strb(dp.addr, dp.size)[b]) ref_mem[dp.addr[7:2]][8*b +: 8] = dp.wdata[8*b +: 8];
        end
        prev_wr = dp.valid && dp.write && !derr;
        dp = ap;
        dp.valid = ap.valid && ap.sel;
        waited = 0;
        if (idx < q.size()) idx++;
      end else begin
        waited++;
      end
      if (cyc > limit) begin
        total++;
        bad++;
        $display("FAIL timeout: transfers stuck after %0d cycles, expected at most %0d", cyc, limit);
        break;
      end
    end
    q.delete();
    HTRANS = 2'b00;
    HSEL   = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; preload = 1'b1; HSEL = 1'b1; HADDR = '0; HTRANS = 2'b00;
    HSIZE = 3'd2; HWRITE = 1'b0; HWDATA = '0;
    last_rdata = '0; last_wea = '0;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge HCLK);
    #1;
    check("reset_hreadyout", HREADYOUT, 1'b1);
    check("reset_hresp", HRESP, 1'b0);
    check("reset_wea", wea, 4'b0000);
    preload = 1'b0;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Write, idle, read: zero-wait read returns the written word.
    add_wr(32'h10, 3'd2, 32'hDEADBEEF); add_idle(); add_rd(32'h10, 3'd2);
    run_queue();
    check("t1_rdata", last_rdata, 32'hDEADBEEF);
    check("t1_stalls", stalls, 0);
    check("t1_model", ref_mem[4], 32'hDEADBEEF);

    // Byte write into lane 3.
    add_wr(32'h10, 3'd2, 32'h11223344); add_wr(32'h13, 3'd0, 32'hAA000000);
    add_idle(); add_rd(32'h10, 3'd2);
    run_queue();
    check("t2_wea", last_wea, 4'b1000);
    check("t2_rdata", last_rdata, 32'hAA223344);
    check("t2_stalls", stalls, 0);

    // Read directly after write: exactly one wait state.
    add_wr(32'h20, 3'd2, 32'h12345678); add_rd(32'h20, 3'd2);
    run_queue();
    check("t3_stalls", stalls, 1);
    check("t3_rdata", last_rdata, 32'h12345678);

    // Eight back-to-back writes then eight reads.
    for (int i = 0; i < 8; i++) add_wr(32'(4 * i), 3'd2, 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 8; i++) add_rd(32'(4 * i), 3'd2);
    run_queue();
    check("t4_stalls", stalls, 1);
    check("t4_rdata", last_rdata, 32'hC0DE0007);

    // Reset during a write data phase aborts the write.
    add_wr(32'h14, 3'd2, 32'h55AA55AA); add_idle();
    run_queue();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h14; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00; HWDATA = 32'hBAD0BAD0;
    @(negedge HCLK);
    check("t5_wea_before", wea, 4'b1111);
    HRESETn = 1'b0;
    #1;
    check("t5_wea_rst", wea, 4'b0000);
    check("t5_rdy_rst", HREADYOUT, 1'b1);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    add_rd(32'h14, 3'd2);
    run_queue();
    check("t5_rdata", last_rdata, 32'h55AA55AA);

    // Misaligned word write.
    add_wr(32'h02, 3'd2, 32'h0BADF00D); add_idle(); add_rd(32'h00, 3'd2);
    run_queue();
`ifdef AHB_RAM_ERR_EN
    check("t6_resp_cycles", resp_cycles, 2);
    check("t6_stalls", stalls, 1);
    check("t6_rdata", last_rdata, 32'hC0DE0000);
`else
    check("t6_resp_cycles", resp_cycles, 0);
    check("t6_rdata", last_rdata, 32'h0BADF00D);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int unsigned r, sz, off;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        add_idle();
      end else begin
        sz = $urandom_range(0, 9);
        sz = (sz < 3) ? 0 : (sz < 6) ? 1 : (sz < 9) ? 2 : $urandom_range(3, 7);
        if ($urandom_range(0, 3) == 0) off = $urandom_range(0, 3);
        else if (sz == 0) off = $urandom_range(0, 3);
        else if (sz == 1) off = 2 * $urandom_range(0, 1);
        else off = 0;
        q.push_back(mk(1'b1, ($urandom_range(0, 9) != 0), r[0],
                       32'($urandom_range(0, NW - 1) * 4 + off), 3'(sz), $urandom));
      end
    end
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
